// File: rtl/uart_cmd_rsp.sv
// 8N1 UART front end: assembles 3-byte commands from RX and transmits single response bytes on TX.
// RX and TX paths are fully independent.
module uart_cmd_rsp #(
  parameter int unsigned BAUD_DIV = 4340,
  parameter int unsigned TO_BITS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err
);

  localparam int unsigned CntW     = $clog2(BAUD_DIV);
  localparam int unsigned ToCycles = TO_BITS * BAUD_DIV;
  localparam int unsigned ToW      = $clog2(ToCycles);
  localparam logic [CntW-1:0] BitLoad  = CntW'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [ToW-1:0]  ToLoad   = ToW'(ToCycles - 1);

  typedef enum logic [1:0] {StRxIdle, StRxStart, StRxData, StRxStop} rx_state_e;
  typedef enum logic {StTxIdle, StTxXmit} tx_state_e;

  // rx_s3_q is the previous synchronized sample, used only for falling-edge detection.
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [23:0]     cmd_q, cmd_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            frm_err_q, frm_err_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic            resp_sent_q, resp_sent_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    frm_err_d  = 1'b0;
    to_cnt_d   = to_cnt_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (rx_state_q)
      StRxIdle: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = StRxStart;
          rx_cnt_d   = HalfLoad;
          if (byte_cnt_q == 2'd0) cmd_rdy_d = 1'b0;
        end else if (byte_cnt_q != 2'd0) begin
          // Inter-byte timeout drops a partially received command.
          if (to_cnt_q == '0) byte_cnt_d = 2'd0;
          else                to_cnt_d   = to_cnt_q - ToW'(1);
        end
      end
      StRxStart: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_state_d = StRxData;
            rx_cnt_d   = BitLoad;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = StRxIdle;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      StRxData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = BitLoad;
          if (rx_bit_q == 3'd7) rx_state_d = StRxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      StRxStop: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = StRxIdle;
          if (rx_s2_q) begin
            to_cnt_d = ToLoad;
            unique case (byte_cnt_q)
              2'd0: begin
                shadow_d[15:8] = rx_shift_q;
                byte_cnt_d     = 2'd1;
              end
              2'd1: begin
                shadow_d[7:0] = rx_shift_q;
                byte_cnt_d    = 2'd2;
              end
              default: begin
                cmd_d      = {shadow_q, rx_shift_q};
                cmd_rdy_d  = 1'b1;
                byte_cnt_d = 2'd0;
              end
            endcase
          end else begin
            frm_err_d  = 1'b1;
            byte_cnt_d = 2'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      default: rx_state_d = StRxIdle;
    endcase
  end

  // TX idles with an all-ones shift register so TX comes straight from a flop.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    resp_sent_d = resp_sent_q;
    case (tx_state_q)
      StTxIdle: begin
        if (send_resp) begin
          tx_state_d  = StTxXmit;
          tx_shift_d  = {1'b1, resp, 1'b0};
          tx_cnt_d    = BitLoad;
          tx_bit_d    = 4'd0;
          resp_sent_d = 1'b0;
        end
      end
      StTxXmit: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BitLoad;
          if (tx_bit_q == 4'd9) begin
            tx_state_d  = StTxIdle;
            tx_shift_d  = '1;
            resp_sent_d = 1'b1;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CntW'(1);
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= StRxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      byte_cnt_q  <= 2'd0;
      shadow_q    <= 16'd0;
      cmd_q       <= 24'd0;
      cmd_rdy_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      to_cnt_q    <= '0;
      tx_state_q  <= StTxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      tx_shift_q  <= '1;
      resp_sent_q <= 1'b0;
    end else begin
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      byte_cnt_q  <= byte_cnt_d;
      shadow_q    <= shadow_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      frm_err_q   <= frm_err_d;
      to_cnt_q    <= to_cnt_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX        = tx_shift_q[0];
  assign tx_busy   = (tx_state_q == StTxXmit);
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;
  assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_rsp.sv
// Directed bench for uart_cmd_rsp at BAUD_DIV=16, TO_BITS=32; inputs driven and outputs sampled on
// the falling clock edge.
module tb_uart_cmd_rsp;

  logic        clk = 1'b0;
  logic        rst, rx, tx, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy, frm_err;
  logic [23:0] cmd;
  logic [7:0]  resp;
  logic        rdy_mid;
  logic        rdy0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          frm_cnt = 0;
  int          base;

  typedef struct {
    logic [23:0] c;
  } cmd_vec_t;

  typedef struct {
    logic [7:0] r;
    logic [9:0] bits;
    bit         dup;
  } tx_vec_t;

  cmd_vec_t cmd_tab[4];
  tx_vec_t  tx_tab[4];

  uart_cmd_rsp #(.BAUD_DIV(16), .TO_BITS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (rx),
    .TX          (tx),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frm_err) frm_cnt = frm_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; with chk set, cmd_rdy/cmd timing is checked around the stop sample.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit chk,
                           input logic [23:0] exp);
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(16);
    end
    rdy_mid = cmd_rdy;
    rx = stop;
    if (chk) begin
      idle(10);
      check("cmd_rdy_early", 32'(cmd_rdy), 32'd0);
      idle(1);
      check("cmd_rdy_set", 32'(cmd_rdy), 32'd1);
      check("cmd_update", 32'(cmd), 32'(exp));
      idle(5);
    end else begin
      idle(16);
    end
    rx = 1'b1;
  endtask

  task automatic send_cmd(input logic [23:0] c);
    send_byte(c[23:16], 1'b1, 1'b0, c);
    rdy0 = rdy_mid;
    send_byte(c[15:8], 1'b1, 1'b0, c);
    send_byte(c[7:0], 1'b1, 1'b1, c);
  endtask

  initial begin
    cmd_tab[0] = '{c: 24'hFFFFFF};
    cmd_tab[1] = '{c: 24'h5A0F3C};
    cmd_tab[2] = '{c: 24'h800001};
    cmd_tab[3] = '{c: 24'h00FF00};
    tx_tab[0] = '{r: 8'hA5, bits: 10'b1101001010, dup: 1'b1};
    tx_tab[1] = '{r: 8'h3C, bits: 10'b1001111000, dup: 1'b0};
    tx_tab[2] = '{r: 8'h00, bits: 10'b1000000000, dup: 1'b1};
    tx_tab[3] = '{r: 8'hFF, bits: 10'b1111111110, dup: 1'b0};

    rst = 1'b1; rx = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    idle(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_resp_sent", 32'(resp_sent), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_frm_err", 32'(frm_err), 32'd0);
    rst = 1'b0;
    idle(5);

    // Basic command and clear.
    send_cmd(24'h020001);
    idle(20);
    clr_cmd_rdy = 1'b1;
    idle(1);
    clr_cmd_rdy = 1'b0;
    check("clr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("cmd_after_clr", 32'(cmd), 32'h020001);

    // Short low glitch is rejected silently.
    base = frm_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_frm_err", 32'(frm_cnt - base), 32'd0);
    check("glitch_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("glitch_cmd", 32'(cmd), 32'h020001);
    send_cmd(24'h0A0B0C);

    // Bad stop bit on byte1.
    send_byte(8'h11, 1'b1, 1'b0, 24'h0);
    base = frm_cnt;
    send_byte(8'h22, 1'b0, 1'b0, 24'h0);
    idle(20);
    check("frm_err_pulse", 32'(frm_cnt - base), 32'd1);
    check("cmd_after_frm_err", 32'(cmd), 32'h0A0B0C);
    send_cmd(24'h441234);

    // Inter-byte timeout discards two stale bytes.
    send_byte(8'hAA, 1'b1, 1'b0, 24'h0);
    send_byte(8'hBB, 1'b1, 1'b0, 24'h0);
    idle(600);
    send_cmd(24'h050002);

    // Back-to-back commands; each new byte0 start clears the previous cmd_rdy.
    for (int k = 0; k < 4; k++) begin
      send_cmd(cmd_tab[k].c);
      check("rdy_clr_on_byte0", 32'(rdy0), 32'd0);
      check("tab_cmd", 32'(cmd), 32'(cmd_tab[k].c));
    end

    // TX frames; a duplicate request mid-frame must be ignored.
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c <= 161; c++) begin
        if (c == 0) begin
          resp = tx_tab[k].r;
          send_resp = 1'b1;
        end
        if (c == 1) begin
          send_resp = 1'b0;
          check("tx_busy_start", 32'(tx_busy), 32'd1);
          check("resp_sent_clr", 32'(resp_sent), 32'd0);
        end
        if (tx_tab[k].dup && c == 50) begin
          resp = ~tx_tab[k].r;
          send_resp = 1'b1;
        end
        if (tx_tab[k].dup && c == 51) send_resp = 1'b0;
        if (c >= 9 && c <= 153 && ((c - 9) % 16) == 0)
          check("tx_bit", 32'(tx), 32'(tx_tab[k].bits[(c - 9) / 16]));
        if (c == 160) check("tx_busy_last", 32'(tx_busy), 32'd1);
        if (c == 161) begin
          check("tx_busy_end", 32'(tx_busy), 32'd0);
          check("resp_sent_set", 32'(resp_sent), 32'd1);
          check("tx_idle", 32'(tx), 32'd1);
        end
        @(negedge clk);
      end
    end

    // Reset in the middle of byte2 while a response is going out.
    send_byte(8'h77, 1'b1, 1'b0, 24'h0);
    send_byte(8'h88, 1'b1, 1'b0, 24'h0);
    rx = 1'b0;
    resp = 8'h5A;
    send_resp = 1'b1;
    idle(1);
    send_resp = 1'b0;
    idle(15);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0 || i == 3) ? 1'b1 : 1'b0;
      idle(16);
    end
    rx = 1'b1;
    idle(8);
    check("pre_rst_tx_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    idle(1);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_cmd", 32'(cmd), 32'd0);
    check("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("mid_rst_resp_sent", 32'(resp_sent), 32'd0);
    check("mid_rst_frm_err", 32'(frm_err), 32'd0);
    rst = 1'b0;
    idle(200);
    check("post_rst_cmd", 32'(cmd), 32'd0);
    check("post_rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    send_cmd(24'h123456);
    check("post_rst_new_cmd", 32'(cmd), 32'h123456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
